mem_dump_streamer: RTL and testbench
====================================

Name: mem_dump_streamer

Overview:
- Walks a word range of data memory after a dump request and streams each word out over a valid/ready interface.
- Sits beside the CPU core on the memory data-read port. Serves as the hardware replacement for the simulation-only memory dump.
- Contains a 2-entry output buffer, so it sustains 1 word/cycle while the sink holds ready high.

Parameters:
- DEPTH_WORDS, 1024: maximum accepted word count; larger requests are clamped to this value.
- CNT_W, 11: width of the word-count port and internal counters; must satisfy 2^CNT_W > DEPTH_WORDS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_dump_req  in  1  start pulse; sampled only in IDLE.
- i_dump_base  in  32  byte start address; bits [1:0] are ignored (word-aligned).
- i_dump_count  in  CNT_W  number of words to dump.
- o_mem_rd_en  out  1  read issued this cycle.
- o_mem_addr_r  out  32  word read address; held at its last value when no read is issued.
- i_mem_data_r  in  32  read data, valid exactly one cycle after the matching o_mem_rd_en.
- o_stream_valid  out  1  output beat valid.
- o_stream_data  out  32  beat data.
- o_stream_addr  out  32  memory address of the beat.
- o_stream_last  out  1  marks the final beat.
- i_stream_ready  in  1  sink accepts the beat.
- o_busy  out  1  high from the request until done.
- o_done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (asynchronous, active-high): FSM goes to IDLE and buffer is emptied. All outputs return 0, including o_mem_addr_r.
- Reset during a dump aborts it immediately. No o_done pulse follows, and the next dump starts clean.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on i_dump_req with count > 0. On entry, latch:
  - addr = {base[31:2], 2'b00};
  - remaining = min(count, DEPTH_WORDS).
- IDLE -> DONE on i_dump_req with count == 0. No reads and no beats are produced.
- i_dump_req is ignored whenever the FSM is not in IDLE.
- RUN, read issue rule: issue a read when remaining > 0 and (buffer occupancy + reads in flight) < 2.
  - Drive o_mem_rd_en = 1 and o_mem_addr_r = addr.
  - Then addr += 4, wrapping modulo 2^32, and remaining decrements.
- Returned data is written into the buffer in the cycle it arrives, tagged with its address.
- Buffer is a FIFO. The head beat drives o_stream_*.
- A beat is consumed when o_stream_valid && i_stream_ready. While the sink stalls, the head stays stable (data, addr, last unchanged).
- Occupancy never exceeds 2. A simultaneous write and pop leaves occupancy unchanged.
- RUN -> DRAIN when remaining reaches 0.
- DRAIN -> DONE when the beat carrying o_stream_last is accepted.
- o_stream_last is 1 only on the beat of the final word (or on the checksum beat, when enabled).
- DONE: o_done = 1 for exactly one cycle, then the FSM returns to IDLE.
- o_busy = 1 in RUN and DRAIN, and 0 in IDLE and DONE.
- Latency: request accepted at edge E0 -> first o_mem_rd_en in the cycle after E0 -> data arrives the next cycle -> first o_stream_valid in the following cycle (3 cycles after E0).
- Throughput: with ready held high, one beat per cycle, no bubbles.

Optional Feature:
- Macro DUMP_CHECKSUM_EN.
- When defined:
  - A 32-bit running sum (modulo 2^32) of all accepted data beats is kept.
  - After the last data beat, one extra beat is sent with o_stream_data = sum, o_stream_addr = 32'hFFFF_FFFC, and o_stream_last = 1. The data beat before it has last = 0.
  - A count == 0 request goes to RUN/DRAIN and sends only the checksum beat (value 0).
- When not defined: no checksum logic exists, and count == 0 goes straight to DONE.

Test Plan:
- Reset mid-dump: assert rst during RUN with a beat pending -> o_stream_valid, o_busy and o_mem_rd_en are 0 immediately; no o_done. A following request for base 0x0, count 1 streams addr 0x0 with last = 1.
- Basic dump: base 0x100, count 4, ready held high, memory word at address A = A ^ 32'hA5A5_0000.
  - First valid 3 cycles after request.
  - 4 consecutive beats at addrs 0x100, 0x104, 0x108, 0x10C with correct data; last only on 0x10C.
  - o_done one cycle after the last beat.
- Backpressure: count 8, ready toggled with pattern 1,0,0,1,...
  - Never more than 2 reads outstanding.
  - Head is stable during stalls; all 8 beats arrive in order with none lost or duplicated.
- Boundaries:
  - base 0xFFFF_FFF8, count 3 -> addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
  - base 0x103 is treated as 0x100.
  - count 2000 is clamped to 1024 beats.
- Request handling:
  - count 0 -> no reads, no beats, o_done 1 cycle after the request (checksum-only beat of 0 when enabled).
  - A second i_dump_req during RUN is ignored.
- DUMP_CHECKSUM_EN: base 0x0, count 3, data 1, 2, 0xFFFF_FFFF -> 3 data beats (last = 0), then beat data 0x0000_0002, addr 0xFFFF_FFFC, last = 1.

Source files
------------

// File: rtl/mem_dump_streamer_if.sv
// Output beat bus of mem_dump_streamer: valid/ready handshake carrying data, source address and last flag.
interface mem_dump_streamer_if;
  logic        valid;
  logic [31:0] data;
  logic [31:0] addr;
  logic        last;
  logic        ready;

  modport master (output valid, data, addr, last, input ready);
  modport slave  (input valid, data, addr, last, output ready);
endinterface

// File: rtl/mem_dump_streamer.sv
// Walks a word range of data memory and streams each word out; first beat 3 cycles after the request, 1 beat/cycle, 2-entry buffer absorbs sink stalls.
// Optional DUMP_CHECKSUM_EN appends a modulo-2^32 sum beat (addr 0xFFFF_FFFC) as the final beat.
module mem_dump_streamer #(
  parameter int DEPTH_WORDS = 1024,
  parameter int CNT_W       = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_dump_req,
  input  logic [31:0]         i_dump_base,
  input  logic [CNT_W-1:0]    i_dump_count,
  output logic                o_mem_rd_en,
  output logic [31:0]         o_mem_addr_r,
  input  logic [31:0]         i_mem_data_r,
  mem_dump_streamer_if.master o_stream,
  output logic                o_busy,
  output logic                o_done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef struct packed {
    logic        last;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH_WORDS);
`ifdef DUMP_CHECKSUM_EN
  localparam logic CS_EN = 1'b1;
`else
  localparam logic CS_EN = 1'b0;
`endif

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_addr, r_rd_addr, r_last_rd_addr;
  logic [CNT_W-1:0] r_remaining, w_count_clamped;
  logic             r_inflight, r_rd_last;
  beat_t            r_buf [2];
  logic             r_wr_ptr, r_rd_ptr;
  logic [1:0]       r_occ, w_slots;
  beat_t            w_head;
  logic             w_fifo_vld, w_out_vld, w_pop, w_fifo_pop, w_issue, w_start;
  logic             w_unused_base_lsb;

  assign w_unused_base_lsb = ^i_dump_base[1:0];
  assign w_head            = r_buf[r_rd_ptr];
  assign w_fifo_vld        = (r_occ != 2'd0);
  assign w_pop             = w_out_vld & o_stream.ready;
  assign w_fifo_pop        = w_pop & w_fifo_vld;
  assign w_count_clamped   = (i_dump_count > MAX_CNT) ? MAX_CNT : i_dump_count;
  assign w_start           = (r_state == S_IDLE) & i_dump_req;

  // Credit the pop happening this cycle so a full pipeline still issues every cycle.
  assign w_slots = r_occ + {1'b0, r_inflight} - {1'b0, w_fifo_pop};
  assign w_issue = (r_state == S_RUN) && (r_remaining != '0) && (w_slots < 2'd2);

`ifdef DUMP_CHECKSUM_EN
  logic [31:0] r_sum;
  logic        w_cs_vld;

  assign w_cs_vld        = (r_state == S_DRAIN) && !w_fifo_vld && !r_inflight;
  assign w_out_vld       = w_fifo_vld | w_cs_vld;
  assign o_stream.data   = w_cs_vld ? r_sum : w_head.data;
  assign o_stream.addr   = w_cs_vld ? 32'hFFFF_FFFC : w_head.addr;
  assign o_stream.last   = w_cs_vld | (w_fifo_vld & w_head.last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
    end else if (w_start) begin
      r_sum <= '0;
    end else if (w_fifo_pop) begin
      r_sum <= r_sum + w_head.data;
    end
  end
`else
  assign w_out_vld       = w_fifo_vld;
  assign o_stream.data   = w_head.data;
  assign o_stream.addr   = w_head.addr;
  assign o_stream.last   = w_fifo_vld & w_head.last;
`endif

  assign o_stream.valid = w_out_vld;

  always_comb begin
    w_state_nxt  = r_state;
    o_mem_rd_en  = w_issue;
    o_mem_addr_r = w_issue ? r_addr : r_last_rd_addr;
    o_busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    o_done       = (r_state == S_DONE);
    case (r_state)
      S_IDLE:  if (i_dump_req) w_state_nxt = ((w_count_clamped == '0) && !CS_EN) ? S_DONE : S_RUN;
      S_RUN:   if ((r_remaining == '0) || (w_issue && (r_remaining == CNT_W'(1)))) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop && o_stream.last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_rd_addr      <= '0;
      r_last_rd_addr <= '0;
      r_remaining    <= '0;
      r_inflight     <= 1'b0;
      r_rd_last      <= 1'b0;
      r_buf[0]       <= '0;
      r_buf[1]       <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_occ          <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_start) begin
        r_addr      <= {i_dump_base[31:2], 2'b00};
        r_remaining <= w_count_clamped;
      end else if (w_issue) begin
        r_addr      <= r_addr + 32'd4;
        r_remaining <= r_remaining - CNT_W'(1);
      end
      if (w_issue) begin
        r_last_rd_addr <= r_addr;
        r_rd_addr      <= r_addr;
        r_rd_last      <= (r_remaining == CNT_W'(1)) & ~CS_EN;
      end
      // Read data is only valid the cycle after the read, so capture it now.
      if (r_inflight) begin
        r_buf[r_wr_ptr] <= '{last: r_rd_last, addr: r_rd_addr, data: i_mem_data_r};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_fifo_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_fifo_pop};
    end
  end
endmodule

// File: tb/tb_mem_dump_streamer.sv
// Scoreboard bench for mem_dump_streamer: directed dumps push expected beats, a negedge monitor pops and compares.
module tb_mem_dump_streamer;
  localparam int CNT_W = 11;
`ifdef DUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             dump_req = 1'b0;
  logic [31:0]      dump_base = '0;
  logic [CNT_W-1:0] dump_count = '0;
  logic             mem_rd_en;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_data = '0;
  logic             busy, done;

  mem_dump_streamer_if sif();

  mem_dump_streamer #(.DEPTH_WORDS(1024), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_dump_req(dump_req), .i_dump_base(dump_base), .i_dump_count(dump_count),
    .o_mem_rd_en(mem_rd_en), .o_mem_addr_r(mem_addr), .i_mem_data_r(mem_data),
    .o_stream(sif), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          cs_data = 1'b0;
  int          ready_mode = 0;
  int          ready_idx = 0;
  logic [31:0] exp_sum = '0;
  int          max_outst = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (cs_data && a == 32'h0) return 32'h1;
    if (cs_data && a == 32'h4) return 32'h2;
    if (cs_data && a == 32'h8) return 32'hFFFF_FFFF;
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_data <= mem_word(mem_addr);

  // ready_mode: 0 high, 1 low, 2 repeating 1,0,0
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       sif.ready = 1'b1;
      1:       sif.ready = 1'b0;
      default: begin sif.ready = (ready_idx % 3 == 0); ready_idx++; end
    endcase
  end

  bit    want_done = 1'b0;
  bit    stalled = 1'b0;
  beat_t prev_head;
  int    outst = 0;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stalled = 1'b0; want_done = 1'b0; outst = 0;
    end else begin
      if (want_done) begin
        checks++;
        if (!done) begin errors++; $display("FAIL done_pulse: o_done=%0b expected 1", done); end
        want_done = 1'b0;
      end
      if (stalled) begin
        checks++;
        if (!sif.valid || sif.addr != prev_head.addr || sif.data != prev_head.data || sif.last != prev_head.last) begin
          errors++;
          $display("FAIL head_stable: valid=%0b addr=%h data=%h last=%0b held addr=%h data=%h last=%0b",
                   sif.valid, sif.addr, sif.data, sif.last, prev_head.addr, prev_head.data, prev_head.last);
        end
      end
      outst = outst + int'(mem_rd_en) - int'(sif.valid && sif.ready);
      if (outst < 0) outst = 0;
      if (outst > max_outst) max_outst = outst;
      if (sif.valid && sif.ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: addr=%h data=%h last=%0b expected none", sif.addr, sif.data, sif.last);
        end else begin
          e = exp_q.pop_front();
          if (sif.addr != e.addr || sif.data != e.data || sif.last != e.last) begin
            errors++;
            $display("FAIL beat: got addr=%h data=%h last=%0b expected addr=%h data=%h last=%0b",
                     sif.addr, sif.data, sif.last, e.addr, e.data, e.last);
          end
        end
        if (sif.last) want_done = 1'b1;
      end
      stalled   = sif.valid && !sif.ready;
      prev_head = '{addr: sif.addr, data: sif.data, last: sif.last};
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic push_data(input logic [31:0] a, input logic [31:0] d, input bit final_word);
    exp_q.push_back('{addr: a, data: d, last: final_word && !CS});
    exp_sum = exp_sum + d;
  endtask

  task automatic push_end();
    if (CS) exp_q.push_back('{addr: 32'hFFFF_FFFC, data: exp_sum, last: 1'b1});
    exp_sum = '0;
  endtask

  task automatic expect_dump(input logic [31:0] base, input int cnt);
    int          n;
    logic [31:0] a;
    n = (cnt > 1024) ? 1024 : cnt;
    a = {base[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      push_data(a, a ^ 32'hA5A5_0000, i == n - 1);
      a = a + 32'd4;
    end
    push_end();
  endtask

  task automatic start(input logic [31:0] base, input int cnt);
    @(posedge clk); #1;
    dump_req = 1'b1; dump_base = base; dump_count = cnt[CNT_W-1:0];
    @(posedge clk); #1;
    dump_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || busy || done) && i < budget) begin
      @(negedge clk); i++;
    end
    checks++;
    if (i >= budget) begin
      errors++;
      $display("FAIL idle_timeout: %0d beats still pending, busy=%0b, expected idle within %0d cycles", exp_q.size(), busy, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat;
    #1;
    check("rst_valid", 32'(sif.valid), 0);
    check("rst_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_valid", 32'(sif.valid), 0);
    check("idle_rd_en", 32'(mem_rd_en), 0);
    check("idle_mem_addr", mem_addr, 0);
    check("idle_done", 32'(done), 0);

    // basic dump with latency check
    push_data(32'h100, 32'hA5A5_0100, 0);
    push_data(32'h104, 32'hA5A5_0104, 0);
    push_data(32'h108, 32'hA5A5_0108, 0);
    push_data(32'h10C, 32'hA5A5_010C, 1);
    push_end();
    start(32'h100, 4);
    @(negedge clk);
    check("first_rd_en", 32'(mem_rd_en), 1);
    check("first_rd_addr", mem_addr, 32'h100);
    lat = 1;
    while (!sif.valid && lat < 20) begin @(negedge clk); lat++; end
    check("first_valid_latency", lat, 3);
    wait_idle(50);

    // backpressure 1,0,0
    ready_mode = 2;
    expect_dump(32'h200, 8);
    start(32'h200, 8);
    wait_idle(200);
    ready_mode = 0;

    // address wrap
    push_data(32'hFFFF_FFF8, 32'h5A5A_FFF8, 0);
    push_data(32'hFFFF_FFFC, 32'h5A5A_FFFC, 0);
    push_data(32'h0000_0000, 32'hA5A5_0000, 1);
    push_end();
    start(32'hFFFF_FFF8, 3);
    wait_idle(50);

    // unaligned base
    push_data(32'h100, 32'hA5A5_0100, 0);
    push_data(32'h104, 32'hA5A5_0104, 1);
    push_end();
    start(32'h103, 2);
    wait_idle(50);

    // clamp to DEPTH_WORDS
    expect_dump(32'h0, 2000);
    start(32'h0, 2000);
    wait_idle(1200);

    // zero count
    expect_dump(32'h40, 0);
    start(32'h40, 0);
    @(negedge clk);
    check("zero_rd_en", 32'(mem_rd_en), 0);
    if (!CS) begin
      check("zero_done", 32'(done), 1);
      check("zero_valid", 32'(sif.valid), 0);
    end
    wait_idle(50);

    // second request during RUN is ignored
    expect_dump(32'h300, 4);
    start(32'h300, 4);
    @(posedge clk); #1;
    dump_req = 1'b1; dump_base = 32'h500; dump_count = 11'd2;
    @(posedge clk); #1;
    dump_req = 1'b0;
    wait_idle(50);

    // reset mid-dump with beats pending
    ready_mode = 1;
    start(32'h400, 8);
    lat = 0;
    while (!sif.valid && lat < 10) begin @(negedge clk); lat++; end
    check("stall_valid", 32'(sif.valid), 1);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("abort_valid", 32'(sif.valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_rd_en", 32'(mem_rd_en), 0);
    exp_q.delete();
    exp_sum = '0;
    @(posedge clk); #1 rst = 1'b0;
    ready_mode = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 0);
    end
    push_data(32'h0, 32'hA5A5_0000, 1);
    push_end();
    start(32'h0, 1);
    wait_idle(50);

`ifdef DUMP_CHECKSUM_EN
    cs_data = 1'b1;
    exp_q.push_back('{addr: 32'h0, data: 32'h1, last: 1'b0});
    exp_q.push_back('{addr: 32'h4, data: 32'h2, last: 1'b0});
    exp_q.push_back('{addr: 32'h8, data: 32'hFFFF_FFFF, last: 1'b0});
    exp_q.push_back('{addr: 32'hFFFF_FFFC, data: 32'h2, last: 1'b1});
    start(32'h0, 3);
    wait_idle(50);
    cs_data = 1'b0;
`endif

    check("max_outstanding_le2", 32'(max_outst <= 2), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
